// File: rtl/xtea_host_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : xtea_host_ctrl                                                  |
// | Host-side initiator for the XTEA core: key load sequencing, word packing,|
// | single-block-in-flight issue, result FIFO and word unpacking.            |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+

module xtea_host_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CORE_LAT   = 7
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [127:0] i_cfg_key,
  input  logic         i_cfg_flag,
  input  logic         i_cfg_start,
  output logic         o_key_ready,
  output logic         o_err,
  input  logic [31:0]  i_s_data,
  input  logic         i_s_valid,
  output logic         o_s_ready,
  output logic [31:0]  o_m_data,
  output logic         o_m_valid,
  input  logic         i_m_ready,
  output logic [127:0] o_core_key,
  output logic         o_core_key_en,
  input  logic         i_core_key_ok,
  output logic         o_core_flag,
  output logic [63:0]  o_core_din,
  output logic         o_core_din_en,
  input  logic [63:0]  i_core_dout,
  input  logic         i_core_dout_en
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_TW = $clog2(CORE_LAT + 1);
  localparam logic [c_TW-1:0] c_LAT   = c_TW'(CORE_LAT);
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_NOKEY   = 2'd0,
    ST_KEYLOAD = 2'd1,
    ST_IDLE    = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic            w_slot, w_push, w_miss, w_stray, w_room;
  logic            w_issue, w_load, w_accept, w_m_fire, w_pop;
  logic [127:0]    w_load_key;
  logic            w_load_flag;
  logic [127:0]    r_key, r_pkey;
  logic            r_flag, r_pflag, r_pend, r_key_en;
  logic [31:0]     r_hi, r_lo;
  logic [1:0]      r_cnt, w_cnt_nxt;
  logic            r_s_ready;
  logic [c_TW-1:0] r_timer;
  logic            r_err;
  logic [63:0]     r_mem [FIFO_DEPTH];
  logic [c_AW-1:0] r_wr, r_rd;
  logic [c_CW-1:0] r_fcnt;
  logic            r_sel;
  logic [63:0]     w_head;

  // The only legal result slot is exactly CORE_LAT cycles after issue.
  assign w_slot   = (r_state == ST_RUN) && (r_timer == c_LAT);
  assign w_push   = w_slot && i_core_dout_en;
  assign w_miss   = w_slot && !i_core_dout_en;
  assign w_stray  = i_core_dout_en && !w_slot;
  assign w_room   = (r_fcnt < c_DEPTH);
  assign w_accept = i_s_valid && r_s_ready;
  assign w_m_fire = o_m_valid && i_m_ready;
  assign w_pop    = w_m_fire && r_sel;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_NOKEY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_load      = 1'b0;
    w_load_key  = i_cfg_key;
    w_load_flag = i_cfg_flag;
    case (r_state)
      ST_NOKEY: begin
        if (i_cfg_start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_KEYLOAD;
        end
      end
      ST_KEYLOAD: begin
        if (i_core_key_ok) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (i_cfg_start) begin
          w_load      = 1'b1;
          w_state_nxt = ST_KEYLOAD;
        end else if ((r_cnt == 2'd2) && w_room) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // A start seen during the block is honoured once the block resolves.
        if (w_slot) begin
          if (r_pend || i_cfg_start) begin
            w_load      = 1'b1;
            w_load_key  = i_cfg_start ? i_cfg_key  : r_pkey;
            w_load_flag = i_cfg_start ? i_cfg_flag : r_pflag;
            w_state_nxt = ST_KEYLOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_NOKEY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_key    <= '0;
      r_flag   <= 1'b0;
      r_key_en <= 1'b0;
      r_pend   <= 1'b0;
      r_pkey   <= '0;
      r_pflag  <= 1'b0;
      r_timer  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_key_en <= w_load;
      if (w_load) begin
        r_key  <= w_load_key;
        r_flag <= w_load_flag;
        r_pend <= 1'b0;
      end else if ((r_state == ST_RUN) && i_cfg_start) begin
        r_pend  <= 1'b1;
        r_pkey  <= i_cfg_key;
        r_pflag <= i_cfg_flag;
      end
      if (w_issue)                          r_timer <= c_TW'(1);
      else if ((r_state == ST_RUN) && !w_slot) r_timer <= r_timer + c_TW'(1);
      r_err <= r_err | w_miss | w_stray;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_issue)       w_cnt_nxt = 2'd0;
    else if (w_accept) w_cnt_nxt = r_cnt + 2'd1;
  end

  // Ready is registered so that it reads 0 while reset is held.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt     <= 2'd0;
      r_s_ready <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_s_ready <= (w_cnt_nxt != 2'd2);
      if (w_accept) begin
        if (r_cnt == 2'd0) r_hi <= i_s_data;
        else               r_lo <= i_s_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_core_dout;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_fcnt <= '0;
      r_sel  <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + c_AW'(1);
      if (w_pop)  r_rd <= r_rd + c_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + c_CW'(1);
        2'b01:   r_fcnt <= r_fcnt - c_CW'(1);
        default: r_fcnt <= r_fcnt;
      endcase
      if (w_m_fire) r_sel <= ~r_sel;
    end
  end

  assign w_head        = r_mem[r_rd];
  assign o_m_valid     = (r_fcnt != '0);
  assign o_m_data      = !o_m_valid ? 32'd0 : (r_sel ? w_head[31:0] : w_head[63:32]);
  assign o_s_ready     = r_s_ready;
  assign o_key_ready   = (r_state == ST_IDLE) || (r_state == ST_RUN);
  assign o_err         = r_err | w_miss;
  assign o_core_key    = r_key;
  assign o_core_key_en = r_key_en;
  assign o_core_flag   = r_flag;
  assign o_core_din    = {r_hi, r_lo};
  assign o_core_din_en = w_issue;

endmodule

`default_nettype wire

// File: tb/tb_xtea_host_ctrl.sv
`default_nettype none
// Bench for xtea_host_ctrl: behavioural core model, random word streams and
// a queue-based reference for packing, ordering and timing.

module tb_xtea_host_ctrl;

  localparam int CORE_LAT   = 7;
  localparam int FIFO_DEPTH = 4;
  localparam int KEY_LAT    = 32;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b0;
  logic [127:0] i_cfg_key = '0;
  logic         i_cfg_flag = 1'b0;
  logic         i_cfg_start = 1'b0;
  logic         o_key_ready, o_err;
  logic [31:0]  i_s_data = '0;
  logic         i_s_valid = 1'b0;
  logic         o_s_ready;
  logic [31:0]  o_m_data;
  logic         o_m_valid;
  logic         i_m_ready = 1'b0;
  logic [127:0] o_core_key;
  logic         o_core_key_en;
  logic         i_core_key_ok = 1'b0;
  logic         o_core_flag;
  logic [63:0]  o_core_din;
  logic         o_core_din_en;
  logic [63:0]  i_core_dout = '0;
  logic         i_core_dout_en = 1'b0;

  xtea_host_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .CORE_LAT(CORE_LAT)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cfg_key(i_cfg_key), .i_cfg_flag(i_cfg_flag), .i_cfg_start(i_cfg_start),
    .o_key_ready(o_key_ready), .o_err(o_err),
    .i_s_data(i_s_data), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
    .o_m_data(o_m_data), .o_m_valid(o_m_valid), .i_m_ready(i_m_ready),
    .o_core_key(o_core_key), .o_core_key_en(o_core_key_en), .i_core_key_ok(i_core_key_ok),
    .o_core_flag(o_core_flag), .o_core_din(o_core_din), .o_core_din_en(o_core_din_en),
    .i_core_dout(i_core_dout), .i_core_dout_en(i_core_dout_en)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic [31:0]  in_q[$], acc_q[$], out_q[$];
  logic [63:0]  din_q[$], dval_q[$];
  int           issue_q[$], due_q[$];
  int           ken_cnt = 0, ken_cyc = 0, keyok_due = -1;
  logic [127:0] ken_key = '0;
  logic         ken_flag = 1'b0;
  bit           suppress = 1'b0;
  int           n_checks = 0, n_pass = 0;

  function automatic logic [63:0] core_f(input logic [63:0] b);
    return {b[31:0], b[63:32]} ^ 64'h9E3779B9_7F4A7C15;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  // Observers: everything is sampled mid-cycle on the falling edge.
  initial forever begin
    @(negedge i_clk);
    if (!i_rst) begin
      if (i_s_valid && o_s_ready && in_q.size() > 0) begin
        acc_q.push_back(i_s_data);
        in_q.delete(0);
      end
      if (o_core_din_en) begin
        issue_q.push_back(cyc);
        din_q.push_back(o_core_din);
        if (!suppress) begin
          due_q.push_back(cyc + CORE_LAT);
          dval_q.push_back(o_core_din);
        end
      end
      if (o_core_key_en) begin
        ken_cnt++;
        ken_cyc   = cyc;
        ken_key   = o_core_key;
        ken_flag  = o_core_flag;
        keyok_due = cyc + KEY_LAT;
      end
      if (o_m_valid && i_m_ready) out_q.push_back(o_m_data);
    end
  end

  // Core model and input word feeder.
  initial forever begin
    @(posedge i_clk); #1;
    i_core_dout_en = 1'b0;
    i_core_key_ok  = 1'b0;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      due_q.delete(0);
      i_core_dout_en = 1'b1;
      i_core_dout    = core_f(dval_q[0]);
      dval_q.delete(0);
    end
    if (keyok_due == cyc) i_core_key_ok = 1'b1;
    i_s_valid = (in_q.size() > 0);
    if (in_q.size() > 0) i_s_data = in_q[0];
  end

  task automatic clear_logs();
    acc_q.delete(); out_q.delete(); din_q.delete(); issue_q.delete();
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) in_q.push_back($urandom);
  endtask

  task automatic wait_out(input string tag, input int n);
    int t = 0;
    while (out_q.size() < n && t < 500) begin step(); t++; end
    check({tag, "_timeout"}, (t < 500), 1'b1);
    repeat (4) step();
  endtask

  task automatic wait_issues(input string tag, input int n);
    int t = 0;
    while (issue_q.size() < n && t < 200) begin step(); t++; end
    check({tag, "_issue_timeout"}, (t < 200), 1'b1);
  endtask

  task automatic wait_key_ready(input string tag);
    int t = 0;
    while (!o_key_ready && t < 200) begin step(); t++; end
    check({tag, "_keyrdy_timeout"}, (t < 200), 1'b1);
  endtask

  // Reference: consecutive accepted word pairs form blocks; each result
  // leaves as its high word then its low word.
  task automatic compare_stream(input string tag);
    logic [63:0] r;
    check({tag, "_n_issue"}, din_q.size(), acc_q.size() / 2);
    check({tag, "_n_out"}, out_q.size(), acc_q.size());
    for (int i = 0; i < din_q.size() && 2*i+1 < acc_q.size(); i++)
      check($sformatf("%s_din%0d", tag, i), din_q[i], {acc_q[2*i], acc_q[2*i+1]});
    for (int i = 0; i < out_q.size() && i < acc_q.size(); i++) begin
      r = core_f({acc_q[2*(i/2)], acc_q[2*(i/2)+1]});
      check($sformatf("%s_word%0d", tag, i), out_q[i], (i % 2 == 0) ? r[63:32] : r[31:0]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_key_ready"}, o_key_ready, 1'b0);
    check({tag, "_err"}, o_err, 1'b0);
    check({tag, "_s_ready"}, o_s_ready, 1'b0);
    check({tag, "_m_valid"}, o_m_valid, 1'b0);
    check({tag, "_m_data"}, o_m_data, 32'd0);
    check({tag, "_core_key"}, o_core_key, 128'd0);
    check({tag, "_core_key_en"}, o_core_key_en, 1'b0);
    check({tag, "_core_flag"}, o_core_flag, 1'b0);
    check({tag, "_core_din"}, o_core_din, 64'd0);
    check({tag, "_core_din_en"}, o_core_din_en, 1'b0);
  endtask

  initial begin
    logic [127:0] k1, k2;
    logic [63:0]  r;
    int           base, prev_ken;

    #2 i_rst = 1'b1;
    #1 check_all_zero("rst");
    repeat (3) step();
    i_rst = 1'b0;
    step();
    check("s_ready_after_rst", o_s_ready, 1'b1);

    // Key load; key input scrambled afterwards to show it is sampled once.
    k1 = 128'h0123456789abcdef0123456789abcdef;
    i_cfg_key = k1; i_cfg_flag = 1'b1; i_cfg_start = 1'b1;
    step();
    i_cfg_start = 1'b0;
    i_cfg_key = {$urandom, $urandom, $urandom, $urandom};
    wait_key_ready("kl");
    check("kl_key_en_count", ken_cnt, 1);
    check("kl_core_key", ken_key, k1);
    check("kl_flag_at_en", ken_flag, 1'b1);
    check("kl_ready_latency", cyc - ken_cyc, KEY_LAT + 1);
    check("kl_core_key_held", o_core_key, k1);

    // Single block.
    i_m_ready = 1'b1;
    clear_logs();
    in_q.push_back(32'hDEADBEEF);
    in_q.push_back(32'h01234567);
    wait_out("single", 2);
    check("single_din", (din_q.size() > 0) ? din_q[0] : 64'd0, 64'hDEADBEEF01234567);
    compare_stream("single");
    check("single_err", o_err, 1'b0);

    // Back-to-back: eight blocks at one block per 8 cycles.
    clear_logs();
    push_words(16);
    wait_out("b2b", 16);
    compare_stream("b2b");
    for (int i = 1; i < issue_q.size(); i++)
      check($sformatf("b2b_spacing%0d", i), issue_q[i] - issue_q[i-1], 8);
    check("b2b_err", o_err, 1'b0);

    // Backpressure: FIFO fills, then the packer stalls with two words.
    clear_logs();
    i_m_ready = 1'b0;
    push_words(12);
    repeat (150) step();
    check("bp_issues_full", issue_q.size(), FIFO_DEPTH);
    check("bp_accepted", acc_q.size(), 2*FIFO_DEPTH + 2);
    check("bp_s_ready", o_s_ready, 1'b0);
    check("bp_m_valid", o_m_valid, 1'b1);
    r = core_f({acc_q[0], acc_q[1]});
    check("bp_head_word", o_m_data, r[63:32]);
    i_m_ready = 1'b1;
    wait_out("bp", 12);
    compare_stream("bp");
    check("bp_err", o_err, 1'b0);

    // Re-key while a block is in flight.
    clear_logs();
    prev_ken = ken_cnt;
    k2 = {$urandom, $urandom, $urandom, $urandom};
    push_words(2);
    wait_issues("rk", 1);
    i_cfg_key = k2; i_cfg_flag = 1'b0; i_cfg_start = 1'b1;
    step();
    i_cfg_start = 1'b0;
    wait_out("rk", 2);
    wait_key_ready("rk");
    check("rk_key_en_count", ken_cnt, prev_ken + 1);
    check("rk_key_en_cycle", ken_cyc, issue_q[0] + CORE_LAT + 1);
    check("rk_core_key", ken_key, k2);
    check("rk_core_flag", o_core_flag, 1'b0);
    compare_stream("rk");

    clear_logs();
    push_words(2);
    wait_out("dec", 2);
    compare_stream("dec");
    check("dec_core_flag", o_core_flag, 1'b0);
    check("dec_err", o_err, 1'b0);

    // Missing core result.
    clear_logs();
    suppress = 1'b1;
    push_words(2);
    wait_issues("miss", 1);
    base = issue_q[0];
    while (cyc < base + CORE_LAT - 1) step();
    @(negedge i_clk);
    check("miss_err_before", o_err, 1'b0);
    @(negedge i_clk);
    check("miss_err_at_slot", o_err, 1'b1);
    suppress = 1'b0;
    repeat (3) step();
    check("miss_no_push", o_m_valid, 1'b0);
    check("miss_err_sticky", o_err, 1'b1);
    clear_logs();
    push_words(2);
    wait_out("recover", 2);
    compare_stream("recover");

    // Asynchronous reset in the middle of a block.
    clear_logs();
    push_words(2);
    wait_issues("arst", 1);
    repeat (2) step();
    #3 i_rst = 1'b1;
    #1 check_all_zero("arst");
    due_q.delete(); dval_q.delete(); in_q.delete();
    repeat (2) step();
    i_rst = 1'b0;
    step();
    check("arst_s_ready", o_s_ready, 1'b1);
    check("arst_nokey", o_key_ready, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule

`default_nettype wire
